// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake and iterative one-bit-per-cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST_SHIFT = 1'b1;
`else
    localparam bit FAST_SHIFT = 1'b0;
`endif

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      op_p0;
    logic [XLEN-1:0] shreg_p0;
    logic [SHW-1:0]  cnt;
    logic            accept;
    logic            is_shift;
    logic            shift_path;
    logic [SHW-1:0]  shamt;

    // Single-cycle result; shift ops only land here with shamt 0 unless the barrel shifter is built.
    function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] op,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SHW-1:0]         sh;
        logic [XLEN-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $unsigned(sa >>> sh);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] shift_step(input logic [3:0] op,
                                                   input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        case (op)
            OP_SLL:  r = {v[XLEN-2:0], 1'b0};
            OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = {1'b0, v[XLEN-1:1]};
        endcase
        return r;
    endfunction

    assign shamt      = operand2[SHW-1:0];
    assign is_shift   = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
    assign shift_path = !FAST_SHIFT && is_shift && (shamt != '0);
    assign accept     = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = shift_path ? SHIFT : DONE;
            SHIFT:   if (cnt == SHW'(1)) state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == DONE);
        busy       = (state != IDLE);
    end

    // Stage p0: captured op and working shift register; contents are don't-care outside a request.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            op_p0    <= alu_op;
            shreg_p0 <= operand1;
        end else if (state == SHIFT) begin
            shreg_p0 <= shift_step(op_p0, shreg_p0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (shift_path) cnt <= shamt;
                        else            alu_result <= alu_compute(alu_op, operand1, operand2);
                    end
                end
                SHIFT: begin
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) alu_result <= shift_step(op_p0, shreg_p0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes expected result/latency, negedge monitor pops and checks.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  alu_op = '0;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] alu_result;
    logic        busy;

    logic rr_rand = 1'b0;
    logic rr_bit  = 1'b1;
    logic rr_dir  = 1'b1;
    assign resp_ready = rr_rand ? rr_bit : rr_dir;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    logic        have = 1'b0;
    logic [31:0] held = '0;
    logic        mon_en = 1'b0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .alu_op(alu_op), .operand1(operand1), .operand2(operand2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rr_bit <= 1'($urandom_range(0, 1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference model from the operation definitions, plain 32-bit arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = b % 32;
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << s;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> s;
            4'b1101: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        int unsigned s;
        s = b % 32;
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if ((op == 4'b0001 || op == 4'b0101 || op == 4'b1101) && s != 0) return int'(s) + 1;
        return 1;
`endif
    endfunction

    // Monitor: first cycle of each response is checked against the scoreboard, later cycles for stability.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (resp_valid) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        chk("stale_resp", 32'(resp_valid), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("result", alu_result, e.res);
                        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                    have = 1'b1;
                    held = alu_result;
                end else begin
                    chk("hold_result", alu_result, held);
                    chk("hold_req_ready", 32'(req_ready), 32'd0);
                end
            end else begin
                have = 1'b0;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        alu_op = op; operand1 = a; operand2 = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 300);
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e.res = model(op, a, b);
        e.lat = model_lat(op, b);
        e.acc = cyc;
        sb.push_back(e);
        req_valid = 1'b0;
        alu_op = 4'($urandom);
        operand1 = $urandom;
        operand2 = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", alu_result, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        issue(4'b0000, 32'd15, 32'd25);
        issue(4'b1000, 32'd10, 32'd20);
        issue(4'b1101, 32'h8000_0000, 32'd4);
        issue(4'b0001, 32'h1234_5678, 32'd8);
        issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'b0101, 32'hF000_000F, 32'd0);
        issue(4'b0101, 32'hF000_000F, 32'd31);
        issue(4'b1101, 32'h8000_0001, 32'd31);
        drain();

        rr_dir = 1'b0;
        issue(4'b0000, 32'hFFFF_FFFF, 32'd2);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_seen", 32'(resp_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
        end
        @(posedge clk); #1 rr_dir = 1'b1;
        @(posedge clk); #1;
        chk("hs_req_ready", 32'(req_ready), 32'd1);
        chk("hs_resp_valid", 32'(resp_valid), 32'd0);
        chk("retain_result", alu_result, 32'd1);

        issue(4'b0000, 32'd15, 32'd25);
        drain();
        issue(4'b0101, 32'hDEAD_BEEF, 32'd20);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_result", alu_result, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        sb.delete();
        have = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        repeat (30) @(negedge clk);
        chk("no_stale_valid", 32'(resp_valid), 32'd0);

        rr_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            issue(op, a, b);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
